// File: rtl/button_events_pkg.sv
// Shared constants for the button event block: event word layout and the
// default debounce interval, also used by the CPU-side register file.
package button_events_pkg;

  localparam int EVT_PRESS_BIT    = 7;
  localparam int EVT_IDX_LSB      = 0;
  localparam int EVT_IDX_W        = 2;
  localparam int DEBOUNCE_DEFAULT = 270000;  // 10 ms at 27 MHz

  function automatic logic [7:0] make_event(input logic press, input logic [EVT_IDX_W-1:0] idx);
    logic [7:0] evt;
    evt = '0;
    evt[EVT_PRESS_BIT] = press;
    evt[EVT_IDX_LSB +: EVT_IDX_W] = idx;
    return evt;
  endfunction

endpackage

// File: rtl/button_events_debouncer.sv
// One push-button: 2-flop synchronizer, inversion to pressed-high, and a
// stable-level counter that toggles the debounced state.
module button_debouncer
  import button_events_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic state,
  output logic toggle
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          synced;

  assign synced = ~sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = '0;
    state_d = state_q;
    toggle  = 1'b0;
    if (synced != state_q) begin
      if (cnt_q == CNT_MAX) begin
        state_d = ~state_q;
        toggle  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer resets to the released pin level so no phantom press follows reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/button_events.sv
// Debounced push-buttons feeding a small press/release event FIFO with
// sticky overflow and a one-cycle interrupt pulse per accepted event.
module button_events
  import button_events_pkg::*;
#(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_raw,
  input  logic                 read_enable,
  input  logic                 interrupt_enable,
  input  logic                 overflow_clear,
  output logic [N_BUTTONS-1:0] state,
  output logic [7:0]           event_data,
  output logic [2:0]           event_count,
  output logic                 empty,
  output logic                 overflow,
  output logic                 interrupt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  logic [N_BUTTONS-1:0] toggle;
  logic [N_BUTTONS-1:0] pending_q, pending_d;
  logic [N_BUTTONS-1:0] dir_q, dir_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             irq_q, irq_d;

  logic             push_req, push_dir, do_push, drop, pop, full;
  logic [1:0]       push_idx;
  logic [7:0]       push_data;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[g]),
      .state  (state[g]),
      .toggle (toggle[g])
    );
  end

  // Arbiter: lowest pending index wins; a toggle this cycle re-arms its flag with the new level.
  always_comb begin
    push_req  = 1'b0;
    push_idx  = '0;
    push_dir  = 1'b0;
    pending_d = pending_q;
    dir_d     = dir_q;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_req = 1'b1;
        push_idx = 2'(i);
        push_dir = dir_q[i];
      end
    end
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (push_req && (push_idx == 2'(i))) pending_d[i] = 1'b0;
      if (toggle[i]) begin
        pending_d[i] = 1'b1;
        dir_d[i]     = ~state[i];
      end
    end
    push_data = make_event(push_dir, push_idx);
  end

  always_comb begin
    pop      = read_enable && (count_q != '0);
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    do_push  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !do_push) count_d = count_q - CNT_W'(1);
    overflow_d = overflow_q;
    if (drop)                overflow_d = 1'b1;
    else if (overflow_clear) overflow_d = 1'b0;
    irq_d = do_push && interrupt_enable;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      dir_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      dir_q      <= dir_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  // Storage needs no reset: contents are only visible while count_q is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign event_data  = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
  assign event_count = 3'(count_q);
  assign empty       = (count_q == '0);
  assign overflow    = overflow_q;
  assign interrupt   = irq_q;

endmodule
